instr_fetch_unit: RTL and testbench

Instruction fetch front end that feeds the decode/control path. It owns the PC and issues word reads to instruction memory over a request/grant + response-valid interface. It buffers returned instructions in a small in-order queue and presents each one, pre-split into RISC-V fields (opcode, funct3, funct7, rd, rs1, rs2), to the control unit through a valid/ready handshake. A redirect port from branch/jump resolution flushes the queue and any in-flight fetches.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch front end.
// Contents: base opcodes, instruction field positions/widths, and the
// fetch_entry_t record ({pc, instr}) held by the fetch queue.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_W      = 5;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_W      = 5;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order queue of fetched instructions.
// Ports: clk, rst_n (sync, active-low); push_i/din_i write an entry,
// pop_i retires the head, flush_i empties the queue (wins over push/pop);
// head_o is the oldest entry, count_o/full_o/empty_o report occupancy.
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = ptr_inc(wr_q);
      if (pop_i)  rd_d = ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Push while full is only legal alongside a pop, so the slot written is
  // the head being retired in the same cycle.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i && !flush_i))
    else $error("fetch_fifo: push into full queue");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads over a
// req/gnt + rvalid interface, queues returned words in order and presents
// the head, pre-split into RISC-V fields, through instr_valid/instr_ready.
// Ports: clk, rst_n (sync, active-low); imem_* memory request/response;
// redirect_valid/redirect_pc from branch resolution; instr_* and field
// outputs towards decode (all zero while no instruction is valid).
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7
);

  localparam int unsigned CW       = $clog2(DEPTH+1);
  localparam logic [CW:0] CRED_MAX = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, count;
  logic            resp_ok, fire, push, pop, full, empty;
  fetch_entry_t    head, push_entry;

  // A response with nothing outstanding can only be a leftover from before
  // reset; it is ignored rather than corrupting the credit count.
  assign resp_ok  = imem_rvalid && (out_q != '0);
  assign imem_req = rst_n && !redirect_valid &&
                    (({1'b0, out_q} + {1'b0, count}) < CRED_MAX);
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_gnt;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q + CW'(fire) - CW'(resp_ok);
    drop_d    = drop_q;
    push      = 1'b0;
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~XLEN'(3);
      resp_pc_d = redirect_pc & ~XLEN'(3);
      // Everything still in flight is stale, already-dropping ones included.
      drop_d    = out_d;
    end else begin
      if (fire) pc_d = pc_q + XLEN'(4);
      if (resp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC[XLEN-1:0];
      resp_pc_q <= RESET_PC[XLEN-1:0];
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  assign push_entry.pc    = resp_pc_q;
  assign push_entry.instr = imem_rdata;
  assign pop = instr_valid && instr_ready && !redirect_valid;

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign instr_valid = rst_n && !empty;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;
  assign opcode      = instr[OPCODE_LSB +: OPCODE_W];
  assign rd          = instr[RD_LSB     +: RD_W];
  assign funct3      = instr[FUNCT3_LSB +: FUNCT3_W];
  assign rs1         = instr[RS1_LSB    +: RS1_W];
  assign rs2         = instr[RS2_LSB    +: RS2_W];
  assign funct7      = instr[FUNCT7_LSB +: FUNCT7_W];

  no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (out_q != '0))
    else $error("instr_fetch_unit: response with nothing outstanding");

  no_queue_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !redirect_valid))
    else $error("instr_fetch_unit: queue overrun");

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] pq[$];
  logic        hold = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0033;
    if (a == 32'h4) return 32'h00A0_0093;
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory model records grants, returns them in order one cycle
  // later unless held; inputs/outputs settle #1 after the edge.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (!rst_n) pq.delete();
    else if (f) pq.push_back(a);
    if (!hold && pq.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = dat(pq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_opcode", opcode, 7'd0);
    chk("rst_funct7", funct7, 7'd0);

    // Streaming fetch
    rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    #0;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    tick();                                        // E1
    chk("addr4", imem_addr, 32'h4);
    chk("lat_valid0", instr_valid, 1'b0);
    tick();                                        // E2
    chk("i0_valid", instr_valid, 1'b1);
    chk("i0_pc", instr_pc, 32'h0);
    chk("i0_opcode", opcode, 7'b0110011);
    chk("i0_funct3", funct3, 3'd0);
    chk("i0_funct7", funct7, 7'd0);
    chk("credit_req0", imem_req, 1'b0);
    tick();                                        // E3
    chk("i1_pc", instr_pc, 32'h4);
    chk("i1_opcode", opcode, 7'b0010011);
    chk("i1_rd", rd, 5'd1);
    chk("i1_rs1", rs1, 5'd0);
    chk("i1_rs2", rs2, 5'd10);
    chk("addr8", imem_addr, 32'h8);

    // Backpressure: queue fills to 2, requests stop
    instr_ready = 1'b0;
    tick(); tick(); tick();                        // E4..E6
    chk("bp_req", imem_req, 1'b0);
    chk("bp_valid", instr_valid, 1'b1);
    chk("bp_head", instr_pc, 32'h4);
    instr_ready = 1'b1;
    tick();                                        // E7
    chk("bp_head2", instr_pc, 32'h8);
    chk("bp_resume_req", imem_req, 1'b1);
    chk("bp_resume_addr", imem_addr, 32'hC);

    // Redirect with two requests outstanding
    hold = 1'b1;
    tick(); tick();                                // E8, E9
    chk("out2_req", imem_req, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();                                        // E10
    redirect_valid = 1'b0; hold = 1'b0;
    #0;
    chk("rd_addr", imem_addr, 32'h100);
    tick();                                        // E11
    chk("drop_valid0", instr_valid, 1'b0);
    tick();                                        // E12
    chk("drop_valid1", instr_valid, 1'b0);
    chk("rd_req", imem_req, 1'b1);
    tick();                                        // E13
    chk("drop_valid2", instr_valid, 1'b0);
    tick();                                        // E14
    chk("rd_valid", instr_valid, 1'b1);
    chk("rd_pc", instr_pc, 32'h100);
    chk("rd_instr", instr, 32'hA500_0100);

    // Redirect coincident with rvalid and a pop
    chk("co_rvalid", imem_rvalid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #0;
    chk("co_req_forced", imem_req, 1'b0);
    tick();                                        // E15
    redirect_valid = 1'b0;
    #0;
    chk("co_empty", instr_valid, 1'b0);
    chk("co_addr", imem_addr, 32'h200);
    tick(); tick();                                // E16, E17
    chk("co_pc", instr_pc, 32'h200);

    // Unaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();                                        // E18
    redirect_valid = 1'b0;
    #0;
    chk("ua_addr", imem_addr, 32'h100);
    chk("ua_req", imem_req, 1'b1);

    // Reset with one request outstanding
    hold = 1'b1;
    tick();                                        // E19
    rst_n = 1'b0; hold = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h100);
    #0;
    chk("mr_req", imem_req, 1'b0);
    chk("mr_valid", instr_valid, 1'b0);
    tick();                                        // E20
    rst_n = 1'b1;
    #0;
    chk("mr_restart", imem_addr, 32'h0);
    chk("mr_valid2", instr_valid, 1'b0);
    tick(); tick();                                // E21, E22
    chk("mr_pc", instr_pc, 32'h0);
    chk("mr_instr", instr, 32'h0000_0033);

    // PC wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();                                        // E23
    redirect_valid = 1'b0;
    #0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();                                        // E24
    chk("wr_wrap", imem_addr, 32'h0);
    tick();                                        // E25
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
